// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//
// Timekeeping stage that feeds the calendar block. It divides clk_100MHz down
// to a 1 Hz tick and keeps 24-hour hours/minutes/seconds in binary. A RUN/SET
// mode FSM lets the user set the time with pre-debounced push buttons.
//
// Ports
//   clk_100MHz  in   1  system clock, all logic on its rising edge
//   reset       in   1  synchronous, active-high reset (priority over all)
//   mode_set    in   1  level: 1 requests SET mode, 0 requests RUN mode
//   inc_hour    in   1  debounced button, rising edge = hour++ (SET only)
//   inc_minute  in   1  debounced button, rising edge = minute++ (SET only)
//   clr_second  in   1  debounced button, rising edge = seconds <= 0 (SET only)
//   hours       out  8  0..23, registered
//   minutes     out  8  0..59, registered
//   seconds     out  8  0..59, registered
//   tick_1Hz    out  1  one-cycle pulse in the last clk cycle of each second
//   end_of_day  out  1  level, high while time == 23:59:59
//   running     out  1  1 in RUN state, 0 in SET state
// -----------------------------------------------------------------------------
module time_keeper #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int DEFAULT_HOUR   = 0,
    parameter int DEFAULT_MINUTE = 0,
    parameter int DEFAULT_SECOND = 0
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       mode_set,
    input  logic       inc_hour,
    input  logic       inc_minute,
    input  logic       clr_second,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       tick_1Hz,
    output logic       end_of_day,
    output logic       running
);

    // Prescaler width; a modulus of 1 would give a zero-width counter, so
    // clamp to at least one bit.
    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    localparam logic [7:0] HOUR_RST   = 8'(DEFAULT_HOUR);
    localparam logic [7:0] MINUTE_RST = 8'(DEFAULT_MINUTE);
    localparam logic [7:0] SECOND_RST = 8'(DEFAULT_SECOND);

    localparam logic [7:0] HOUR_LAST = 8'd23;
    localparam logic [7:0] MIN_LAST  = 8'd59;
    localparam logic [7:0] SEC_LAST  = 8'd59;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_e;

    // Button history bit order: {hour, minute, second}.
    typedef struct packed {
        logic hour;
        logic minute;
        logic second;
    } btn_t;

    state_e             state_q,    state_d;
    logic [PRESC_W-1:0] presc_q,    presc_d;
    logic               tick_q,     tick_d;
    logic [7:0]         hours_q,    hours_d;
    logic [7:0]         minutes_q,  minutes_d;
    logic [7:0]         seconds_q,  seconds_d;
    btn_t               btn_hist_q, btn_hist_d;
    btn_t               btn_now;
    btn_t               btn_rise;

    // -------------------------------------------------------------------------
    // Mode FSM: the requested mode is simply the level of mode_set, taking
    // effect on the next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (mode_set)  state_d = ST_SET;
            ST_SET:  if (!mode_set) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Prescaler and tick.
    // The counter is held at 0 in SET so that the first second after
    // returning to RUN is a full CLK_FREQ_HZ cycles long. tick is registered
    // from the *next* prescaler value, so it is high exactly in the cycle in
    // which the prescaler holds its last value. Gating with state_d keeps the
    // tick out of the first SET cycle after a RUN->SET transition.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        presc_d = '0;
        if (state_q == ST_RUN) begin
            presc_d = (presc_q >= PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
        end
        tick_d = (state_d == ST_RUN) && (presc_d == PRESC_MAX);
    end

    // -------------------------------------------------------------------------
    // Button edge detection. History updates every cycle in both modes, so a
    // button pressed in RUN and held into SET does not fire on the mode
    // change.
    // -------------------------------------------------------------------------
    always_comb begin
        btn_now    = '{hour: inc_hour, minute: inc_minute, second: clr_second};
        btn_rise   = btn_now & ~btn_hist_q;
        btn_hist_d = btn_now;
    end

    // -------------------------------------------------------------------------
    // Time counters.
    // A tick can only be high while state_q is RUN, so the tick path and the
    // button path never compete. Comparisons use >= so that any out-of-range
    // value reloads 0 on its next increment.
    // -------------------------------------------------------------------------
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;

        if (tick_q) begin
            if (seconds_q >= SEC_LAST) begin
                seconds_d = '0;
                if (minutes_q >= MIN_LAST) begin
                    minutes_d = '0;
                    hours_d   = (hours_q >= HOUR_LAST) ? '0 : hours_q + 8'd1;
                end else begin
                    minutes_d = minutes_q + 8'd1;
                end
            end else begin
                seconds_d = seconds_q + 8'd1;
            end
        end else if (state_q == ST_SET) begin
            // Each button acts on its own field only: no carries in SET.
            if (btn_rise.hour) begin
                hours_d = (hours_q >= HOUR_LAST) ? '0 : hours_q + 8'd1;
            end
            if (btn_rise.minute) begin
                minutes_d = (minutes_q >= MIN_LAST) ? '0 : minutes_q + 8'd1;
            end
            if (btn_rise.second) begin
                seconds_d = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset is synchronous and overrides everything,
    // including a tick that would otherwise have been issued this cycle.
    // History resets to 1 so a button held through reset needs a fresh press.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ST_RUN;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            hours_q    <= HOUR_RST;
            minutes_q  <= MINUTE_RST;
            seconds_q  <= SECOND_RST;
            btn_hist_q <= '1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            btn_hist_q <= btn_hist_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. end_of_day decodes the registered counters, so it is stable
    // for the whole final second and is valid at the tick's rising edge.
    // -------------------------------------------------------------------------
    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign tick_1Hz   = tick_q;
    assign running    = (state_q == ST_RUN);
    assign end_of_day = (hours_q == HOUR_LAST) && (minutes_q == MIN_LAST) &&
                        (seconds_q == SEC_LAST);

endmodule
